// File: rtl/riscv_dmem_mmio_if.sv
// -----------------------------------------------------------------------------
// riscv_dmem_mmio_if
// Bus bundle between the single-cycle RISC-V core, the data memory / MMIO
// block and the character-output consumer (testbench or UART).
//
// Signals:
//   we        store strobe from the core
//   be[3:0]   byte enables; be[i] qualifies wd[8i+7:8i]
//   a[31:0]   byte address
//   wd[31:0]  store data, already lane-aligned by the core
//   rd[31:0]  load data (combinational)
//   stall     core must hold the current store (combinational)
//   io_valid  TX FIFO non-empty
//   io_data   TX FIFO head byte
//   io_ready  consumer accepts the head byte this cycle
//
// Modports:
//   slave  - the memory/MMIO block
//   master - the core plus character consumer (driven by the testbench)
// -----------------------------------------------------------------------------
interface riscv_dmem_mmio_if;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        io_valid;
  logic [7:0]  io_data;
  logic        io_ready;

  modport slave (
    input  we, be, a, wd, io_ready,
    output rd, stall, io_valid, io_data
  );

  modport master (
    output we, be, a, wd, io_ready,
    input  rd, stall, io_valid, io_data
  );
endinterface

// File: rtl/riscv_dmem_mmio.sv
// -----------------------------------------------------------------------------
// riscv_dmem_mmio
// Data memory for the single-cycle RISC-V core with a 16-byte I/O window.
//
//   * Byte-lane RAM of DEPTH_WORDS 32-bit words (SB/SH/SW), combinational
//     loads, not cleared by reset. Upper address bits are ignored, so the
//     RAM aliases across the address space.
//   * I/O window at IO_BASE (word offsets):
//       0 TX_DATA (W)  pushes wd[7:0] into the TX FIFO when be[0] is set
//       1 STATUS  (R)  [0]=full, [1]=empty, [12:8]=FIFO count
//       2 CYCLES  (R)  free-running cycle counter
//       3 reserved     reads 0, writes ignored
//   * TX FIFO of FIFO_DEPTH bytes drained through io_valid/io_ready. The
//     core is stalled when it stores into a full FIFO that is not popping.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (FIFO and cycle counter only)
//   bus  riscv_dmem_mmio_if.slave (core bus and character-output stream)
// -----------------------------------------------------------------------------
module riscv_dmem_mmio #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] IO_BASE     = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  riscv_dmem_mmio_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [1:0]    OFF_TX     = 2'd0;
  localparam logic [1:0]    OFF_STATUS = 2'd1;
  localparam logic [1:0]    OFF_CYCLES = 2'd2;

  // Storage
  logic [31:0]   mem_q  [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  // FIFO control and cycle counter
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycles_q;

  // Decode and handshake terms
  logic          io_sel_s;
  logic [1:0]    io_off_s;
  logic [AW-1:0] word_idx_s;
  logic          ram_we_s;
  logic          full_s;
  logic          empty_s;
  logic          push_req_s;
  logic          pop_s;
  logic          push_s;
  logic [31:0]   status_s;
  logic [31:0]   rd_s;
  logic          unused_addr_s;

  // The byte offset within a word never selects anything.
  assign unused_addr_s = ^bus.a[1:0];

  // Address decode: I/O window versus RAM word index (upper bits alias).
  always_comb begin
    io_sel_s   = (bus.a[31:4] == IO_BASE[31:4]);
    io_off_s   = bus.a[3:2];
    word_idx_s = bus.a[AW+1:2];
    ram_we_s   = bus.we & ~io_sel_s;
  end

  // FIFO status and handshake. A store into a full FIFO still goes through
  // when the consumer pops in the same cycle, because a slot frees up.
  always_comb begin
    full_s     = (count_q == FULL_CNT);
    empty_s    = (count_q == {CW{1'b0}});
    pop_s      = ~empty_s & bus.io_ready;
    push_req_s = bus.we & io_sel_s & (io_off_s == OFF_TX) & bus.be[0];
    push_s     = push_req_s & (~full_s | pop_s);
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO control and cycle counter registers; reset drops queued bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      cycles_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cycles_q <= cycles_q + 32'd1;
    end
  end

  // FIFO byte storage; a push during reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= bus.wd[7:0];
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= bus.wd[8*i +: 8];
        end
      end
    end
  end

  // STATUS register image.
  always_comb begin
    status_s            = 32'd0;
    status_s[0]         = full_s;
    status_s[1]         = empty_s;
    status_s[8 +: CW]   = count_q;
  end

  // Load data mux: RAM word or I/O register (write-only/reserved read 0).
  always_comb begin
    rd_s = 32'd0;
    if (io_sel_s) begin
      case (io_off_s)
        OFF_STATUS: rd_s = status_s;
        OFF_CYCLES: rd_s = cycles_q;
        default:    rd_s = 32'd0;
      endcase
    end else begin
      rd_s = mem_q[word_idx_s];
    end
  end

  // io_valid comes from registered occupancy, so a byte pushed into an empty
  // FIFO is never forwarded in the cycle it is stored.
  assign bus.rd       = rd_s;
  assign bus.stall    = push_req_s & full_s & ~pop_s;
  assign bus.io_valid = ~empty_s;
  assign bus.io_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_mmio
// Self-checking bench for riscv_dmem_mmio. A behavioural model (word array,
// byte queue, cycle count) predicts every output; directed steps follow the
// test plan, then a randomized phase mixes RAM, I/O, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_mmio;
  localparam int DEPTH = 256;
  localparam int FD    = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  riscv_dmem_mmio_if bus();

  riscv_dmem_mmio #(
    .DEPTH_WORDS (DEPTH),
    .IO_BASE     (32'h8000_0000),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_q [$];
  logic [31:0] m_cyc;

  function automatic bit is_io(logic [31:0] addr);
    return (addr & 32'hFFFF_FFF0) == 32'h8000_0000;
  endfunction

  function automatic int widx(logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] addr);
    int n;
    int off;
    n   = m_q.size();
    off = int'((addr >> 2) % 4);
    if (!is_io(addr)) return m_mem[widx(addr)];
    if (off == 1) return 32'((n == FD ? 1 : 0) + (n == 0 ? 2 : 0) + n * 256);
    if (off == 2) return m_cyc;
    return 32'd0;
  endfunction

  function automatic bit exp_push_req();
    return bus.we && is_io(bus.a) && (((bus.a >> 2) % 4) == 0) && bus.be[0];
  endfunction

  function automatic bit exp_pop();
    return (m_q.size() > 0) && bus.io_ready;
  endfunction

  function automatic bit exp_stall();
    return exp_push_req() && (m_q.size() == FD) && !exp_pop();
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
    bus.we = we;
    bus.be = be;
    bus.a  = addr;
    bus.wd = wd;
  endtask

  // Compare every output with the model for the current inputs.
  task automatic check_all(string tag);
    #1;
    chk({tag, ".rd"},    bus.rd, exp_rd(bus.a));
    chk({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall()));
    chk({tag, ".valid"}, 32'(bus.io_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk({tag, ".data"}, 32'(bus.io_data), 32'(m_q[0]));
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit pop_e;
    bit push_e;
    int w;
    pop_e  = exp_pop();
    push_e = exp_push_req() && (m_q.size() < FD || pop_e);
    @(posedge clk);
    if (bus.we && !is_io(bus.a)) begin
      w = widx(bus.a);
      for (int i = 0; i < 4; i++)
        if (bus.be[i]) m_mem[w][8*i +: 8] = bus.wd[8*i +: 8];
    end
    if (rst) begin
      m_q.delete();
      m_cyc = 32'd0;
    end else begin
      if (pop_e) void'(m_q.pop_front());
      if (push_e) m_q.push_back(bus.wd[7:0]);
      m_cyc = m_cyc + 32'd1;
    end
    #1;
  endtask

  initial begin
    logic [7:0]  msg [3];
    logic [31:0] addr;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;

    // ---- Reset state ----
    rst = 1'b1;
    bus.io_ready = 1'b0;
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst.status", bus.rd, 32'h0000_0002);
    chk("rst.valid", 32'(bus.io_valid), 32'd0);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 4'b0000, 32'h8000_0008, 32'd0);
    #1;
    chk("cyc.zero", bus.rd, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("cyc.five", bus.rd, 32'd5);

    // ---- Initialise every RAM word ----
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'b1111, 32'(i * 4), $urandom());
      tick();
    end
    drive(1'b0, 4'b0000, 32'h0000_0024, 32'd0);
    check_all("fill");

    // ---- Byte lanes ----
    drive(1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, 4'b0100, 32'h0000_0010, 32'h0055_0000);
    #1;
    chk("lane.sw", bus.rd, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, 4'b0011, 32'h0000_0010, 32'h0000_1234);
    #1;
    chk("lane.sb", bus.rd, 32'hDE55_BEEF);
    tick();
    drive(1'b0, 4'b0000, 32'h0000_0010, 32'd0);
    #1;
    chk("lane.sh", bus.rd, 32'hDE55_1234);
    drive(1'b0, 4'b0000, 32'h0000_0410, 32'd0);
    #1;
    chk("lane.alias", bus.rd, 32'hDE55_1234);

    // ---- Print ordering with io_ready high ----
    bus.io_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 32'h8000_0000, {24'd0, msg[i]});
      check_all("print");
      chk("print.nostall", 32'(bus.stall), 32'd0);
      tick();
      #1;
      chk("print.valid", 32'(bus.io_valid), 32'd1);
      chk("print.byte", 32'(bus.io_data), 32'(msg[i]));
    end
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    tick();
    #1;
    chk("print.idle", 32'(bus.io_valid), 32'd0);

    // ---- Backpressure and full ----
    bus.io_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 4'b0001, 32'h8000_0000, 32'(k));
      check_all("bp.push");
      tick();
    end
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    #1;
    chk("bp.status_full", bus.rd, 32'h0000_0801);
    drive(1'b1, 4'b0001, 32'h8000_0000, 32'h0000_0009);
    #1;
    chk("bp.stall", 32'(bus.stall), 32'd1);
    chk("bp.head", 32'(bus.io_data), 32'h01);
    tick();
    #1;
    chk("bp.stall_hold", 32'(bus.stall), 32'd1);
    chk("bp.head_stable", 32'(bus.io_data), 32'h01);
    bus.io_ready = 1'b1;
    check_all("bp.release");
    chk("bp.nostall", 32'(bus.stall), 32'd0);
    tick();
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    #1;
    chk("bp.still_full", bus.rd, 32'h0000_0801);
    for (int k = 2; k <= 9; k++) begin
      check_all("bp.drain");
      chk("bp.drain_byte", 32'(bus.io_data), 32'(k));
      tick();
    end
    #1;
    chk("bp.empty", bus.rd, 32'h0000_0002);

    // ---- Status/empty ----
    bus.io_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'h8000_0000, 32'h0000_0077);
    tick();
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    #1;
    chk("st.one", bus.rd, 32'h0000_0100);
    bus.io_ready = 1'b1;
    tick();
    #1;
    chk("st.popped", bus.rd, 32'h0000_0002);

    // ---- CYCLES: write ignored, wrap ----
    drive(1'b1, 4'b1111, 32'h8000_0008, 32'h1234_5678);
    tick();
    drive(1'b0, 4'b0000, 32'h8000_0008, 32'd0);
    check_all("cyc.wr_ignored");
    force dut.cycles_q = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #1;
    chk("cyc.max", bus.rd, 32'hFFFF_FFFF);
    release dut.cycles_q;
    tick();
    #1;
    chk("cyc.wrap", bus.rd, 32'd0);

    // ---- Reset mid-operation ----
    bus.io_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'b0001, 32'h8000_0000, 32'(8'hA0 + k));
      tick();
    end
    bus.io_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    #1;
    chk("mid.valid", 32'(bus.io_valid), 32'd0);
    chk("mid.status", bus.rd, 32'h0000_0002);
    drive(1'b0, 4'b0000, 32'h0000_0010, 32'd0);
    #1;
    chk("mid.ram", bus.rd, 32'hDE55_1234);
    drive(1'b0, 4'b0000, 32'h0000_0410, 32'd0);
    #1;
    chk("mid.alias", bus.rd, 32'hDE55_1234);

    // ---- Randomized mix ----
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 1) == 0)
        addr = 32'h8000_0000 | (($urandom_range(0, 3) == 0 ? 32'(1 + $urandom_range(0, 2)) : 32'd0) << 2)
               | 32'($urandom_range(0, 3));
      else
        addr = $urandom();
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), addr, $urandom());
      bus.io_ready = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      check_all("rand");
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 4'b0000, 32'h8000_0004, 32'd0);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_dmem_mmio.md
Name: riscv_dmem_mmio

Overview:
- Data memory for the single-cycle RISC-V core with a memory-mapped I/O window.
- Byte-lane RAM supports SB/SH/SW stores; loads are combinational.
- Character-output port is buffered through a TX FIFO with a valid/ready handshake to the testbench or UART. The core stalls when that FIFO is full.
- Adds a STATUS register and a free-running cycle counter readable by software.

Parameters:
- DEPTH_WORDS, 256, RAM depth in 32-bit words; power of two, 16..4096.
- IO_BASE, 32'h8000_0000, base of the 16-byte I/O window; low 4 bits zero.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  store strobe from core.
- be  in  4  byte enables; be[i] writes wd[8i+7:8i].
- a  in  32  byte address.
- wd  in  32  store data, already lane-aligned by core.
- rd  out  32  load data, combinational.
- stall  out  1  core must hold the current store; combinational.
- io_valid  out  1  TX FIFO non-empty.
- io_data  out  8  TX FIFO head byte.
- io_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Decode: io_sel = (a[31:4] == IO_BASE[31:4]). Otherwise RAM, word index a[$clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so RAM aliases/wraps.
- RAM writes: on posedge, if we & !io_sel, lanes with be[i]=1 are updated and other lanes are held. RAM is not cleared by rst.
- RAM reads: rd = RAM[index] when !io_sel.
- I/O registers, offset a[3:2]:
  - 0 TX_DATA (W): we & be[0] pushes wd[7:0]; reads 0.
  - 1 STATUS (R): [0]=full, [1]=empty, [12:8]=count, other bits 0.
  - 2 CYCLES (R): 32-bit counter; +1 every cycle after reset; wraps 0xFFFF_FFFF->0.
  - 3: reserved; reads 0, writes ignored.
  - Writes to STATUS/CYCLES are ignored.
- Push request: push_req = we & io_sel & a[3:2]==0 & be[0].
- Pop: pop = io_valid & io_ready.
- Stall:
  - stall = push_req & full & !pop.
  - While stall=1 no push occurs, and the core re-presents the store next cycle.
  - Full with simultaneous pop: push is accepted, count unchanged, no stall.
- Simultaneous push & pop when not empty: count unchanged, head advances, new byte goes to tail.
- Push into empty FIFO: io_valid rises the cycle after the store edge. Bytes are never forwarded combinationally to io_data.
- io_data: holds the head byte while io_valid=1 & io_ready=0, and must not change. io_data is don't-care when io_valid=0.
- FIFO is strict FIFO order. Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is 0..FIFO_DEPTH.
- Reset (rst=1 at posedge): FIFO empty (count=0, pointers 0), io_valid=0, CYCLES=0, stall=0.
  - Reset mid-stream discards queued bytes.
  - A push or pop in the reset cycle is ignored.
- Latency: RAM store is visible on rd the cycle after the edge. STATUS/count reflect a push the cycle after the edge.

Test Plan:
- Byte lanes: SW 0xDEADBEEF @0x10; SB 0x55 be=0100 @0x10 -> rd@0x10 = 0xDE55BEEF; SH 0x1234 be=0011 -> 0xDE551234.
- Print ordering: with io_ready=1, store 'H','i','\n' to 0x8000_0000 in consecutive cycles -> io_valid pulses deliver 0x48, 0x69, 0x0A in order, each one cycle after its store; stall never asserts.
- Backpressure/full: io_ready=0, push 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> STATUS=0x0801 after 8; 9th store holds stall=1; raise io_ready -> 0x09 accepted that cycle (no stall). Drain order is 0x01..0x09 and io_data is stable while waiting.
- Status/empty: after reset STATUS=0x0000_0002; push one byte -> next cycle 0x0000_0100; pop -> 0x0000_0002.
- CYCLES: release reset, read 0x8000_0008 after N cycles -> N. Write to it is ignored. Force the counter to 0xFFFF_FFFF in the bench -> next cycle reads 0.
- Reset mid-operation: 5 bytes queued with io_ready=0, assert rst one cycle -> io_valid=0, STATUS empty. RAM contents at 0x10 are preserved. Address 0x0000_0410 aliases 0x10 (DEPTH_WORDS=256).
